// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle CPU core with an explicit FSM sequencer.
//   8-bit instructions, DATA_W-wide datapath and four registers R0..R3.
//   Instruction and data memories are external and use req/ack handshakes,
//   so either memory may insert any number of wait cycles.
//
// Optional feature: define MC_CPU_TRACE_EN to add the retire trace ports
//   (o_retire_valid / o_retire_pc / o_retire_instr).
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              begin/resume execution from IDLE or HALTED
//   o_imem_req/addr      instruction fetch request, address = pc
//   i_imem_rdata/ack     fetched instruction, fetch complete
//   o_dmem_req/we        data access request, 1 = store
//   o_dmem_addr/wdata    data address (Rb), store data (Ra)
//   i_dmem_rdata/ack     load data, access complete
//   o_busy               FSM not in IDLE/HALTED
//   o_halted             HALT executed
//   o_ovf                signed overflow of last ADD/SUB/ADDI
//   o_pc                 current program counter
module mc_cpu_core #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [7:0]        i_imem_rdata,
    input  logic              i_imem_ack,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    input  logic              i_dmem_ack,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_ovf,
`ifdef MC_CPU_TRACE_EN
    output logic              o_retire_valid,
    output logic [ADDR_W-1:0] o_retire_pc,
    output logic [7:0]        o_retire_instr,
`endif
    output logic [ADDR_W-1:0] o_pc
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2,
                           OP_AND  = 4'h3, OP_OR   = 4'h4, OP_XOR  = 4'h5,
                           OP_SLTU = 4'h6, OP_ADDI = 4'h7, OP_MOV  = 4'h8,
                           OP_SHL  = 4'h9, OP_LW   = 4'hA, OP_SW   = 4'hB,
                           OP_BEQ  = 4'hC, OP_BNE  = 4'hD, OP_JR   = 4'hE,
                           OP_HALT = 4'hF;

    localparam int MSB = DATA_W - 1;

    state_t                         r_state, w_state_nxt;
    logic [ADDR_W-1:0]              r_pc, r_npc;
    logic [3:0][DATA_W-1:0]         r_rf;
    logic [7:0]                     r_ir;
    logic [DATA_W-1:0]              r_a, r_b, r_res;
    logic                           r_ovf, r_ovf_nxt, r_halted;

    logic [3:0]                     w_op;
    logic [1:0]                     w_ra, w_rb;
    logic [DATA_W-1:0]              w_imm, w_sum, w_diff, w_addi, w_alu;
    logic                           w_alu_ovf, w_eq, w_wr_en, w_ovf_op;
    logic [ADDR_W-1:0]              w_pc_inc, w_off, w_rb_addr, w_npc;

    assign w_op  = r_ir[7:4];
    assign w_ra  = r_ir[3:2];
    assign w_rb  = r_ir[1:0];
    assign w_imm = DATA_W'(r_ir[1:0]);

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;
    assign w_addi = r_a + w_imm;
    assign w_eq   = (r_a == r_b);

    // Rb as an address: zero-extended or truncated to ADDR_W.
    assign w_rb_addr = ADDR_W'(r_b);
    // Branch offset: R0 sign-extended or truncated to ADDR_W.
    assign w_off     = ADDR_W'($signed(r_rf[0]));
    assign w_pc_inc  = r_pc + ADDR_W'(1);

    // Ops that write Ra in WB: ADD..SHL and LW form one contiguous range.
    assign w_wr_en  = (w_op >= OP_ADD) && (w_op <= OP_LW);
    assign w_ovf_op = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADDI);

    always_comb begin
        w_alu     = r_a;
        w_alu_ovf = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_alu     = w_sum;
                w_alu_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_alu     = w_diff;
                w_alu_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            OP_SLTU: w_alu = DATA_W'(r_a < r_b);
            OP_ADDI: begin
                w_alu     = w_addi;
                w_alu_ovf = (r_a[MSB] == w_imm[MSB]) && (w_addi[MSB] != r_a[MSB]);
            end
            OP_MOV:  w_alu = r_b;
            OP_SHL:  w_alu = r_b << 1;
            default: w_alu = r_a;
        endcase
    end

    always_comb begin
        w_npc = w_pc_inc;
        case (w_op)
            OP_BEQ:  if (w_eq)  w_npc = r_pc + w_off;
            OP_BNE:  if (!w_eq) w_npc = r_pc + w_off;
            OP_JR:   w_npc = w_rb_addr;
            default: w_npc = w_pc_inc;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_FETCH;
            S_FETCH:  if (i_imem_ack) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = (w_op == OP_HALT) ? S_HALTED : S_EXEC;
            S_EXEC:   w_state_nxt = (w_op == OP_LW || w_op == OP_SW) ? S_MEM : S_WB;
            S_MEM:    if (i_dmem_ack) w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_FETCH;
            S_HALTED: if (i_start) w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= ADDR_W'(RESET_PC);
            r_npc     <= '0;
            r_rf      <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
            r_ovf_nxt <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: if (i_imem_ack) r_ir <= i_imem_rdata;
                S_DECODE: begin
                    r_a <= r_rf[w_ra];
                    r_b <= r_rf[w_rb];
                    if (w_op == OP_HALT) begin
                        r_pc     <= w_pc_inc;
                        r_halted <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_res     <= w_alu;
                    r_ovf_nxt <= w_alu_ovf;
                    r_npc     <= w_npc;
                end
                S_MEM: if (i_dmem_ack && w_op == OP_LW) r_res <= i_dmem_rdata;
                // All architectural state commits here, so an abort by reset
                // before WB leaves no partial update behind.
                S_WB: begin
                    if (w_wr_en)  r_rf[w_ra] <= r_res;
                    if (w_ovf_op) r_ovf      <= r_ovf_nxt;
                    r_pc <= r_npc;
                end
                S_HALTED: if (i_start) r_halted <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_imem_req   = (r_state == S_FETCH);
    assign o_imem_addr  = r_pc;
    assign o_dmem_req   = (r_state == S_MEM);
    assign o_dmem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign o_dmem_addr  = (r_state == S_MEM) ? w_rb_addr : '0;
    assign o_dmem_wdata = (r_state == S_MEM) ? r_a : '0;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign o_halted     = r_halted;
    assign o_ovf        = r_ovf;
    assign o_pc         = r_pc;

`ifdef MC_CPU_TRACE_EN
    // pc only advances in WB (or DECODE for HALT), so during the retire
    // cycle it still holds the instruction's fetch address.
    assign o_retire_valid = (r_state == S_WB) || (r_state == S_DECODE && w_op == OP_HALT);
    assign o_retire_pc    = o_retire_valid ? r_pc : '0;
    assign o_retire_instr = o_retire_valid ? r_ir : '0;
`endif

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
- Parametrised multicycle CPU core: 8-bit instructions, DATA_W-wide datapath, four-entry register file, explicit FSM sequencing.
- Instruction and data memories sit outside the core, each on a req/ack handshake, so memories with variable latency can be attached.
- Adds start/halt control, an overflow flag and a defined reset over the previous 8-bit single-width core.

Parameters:
- DATA_W, 8, register/ALU/data width (>=2)
- ADDR_W, 8, instruction and data address width
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin/resume execution from IDLE or HALTED
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_rdata  in  8  instruction, valid when imem_ack
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack
- dmem_ack  in  1  data access complete
- busy  out  1  FSM not in IDLE/HALTED
- halted  out  1  HALT executed
- ovf  out  1  signed overflow of last ADD/SUB/ADDI
- pc  out  ADDR_W  current program counter

Behaviour:
- Reset (rst sampled high at clk edge): state=IDLE, pc=RESET_PC, R0..R3=0, all outputs 0 except pc. Reset overrides start, ack and any in-flight access. req drops at that edge and no partial writeback occurs.
- Encoding: op=[7:4], a=[3:2], b=[1:0].
  - 0000 NOP
  - 0001 ADD Ra+=Rb
  - 0010 SUB Ra-=Rb
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 SLTU Ra=(Ra<Rb)
  - 0111 ADDI Ra+=zext(b)
  - 1000 MOV Ra=Rb
  - 1001 SHL Ra=Rb<<1
  - 1010 LW Ra=M[Rb]
  - 1011 SW M[Rb]=Ra
  - 1100 BEQ
  - 1101 BNE
  - 1110 JR pc=Rb[ADDR_W-1:0]
  - 1111 HALT
- Arithmetic is mod 2^DATA_W.
  - ovf updates only on ADD/SUB/ADDI, as two's-complement signed overflow; it holds otherwise.
  - Memory address = Rb zero-extended or truncated to ADDR_W.
- Branches: taken when (Ra==Rb) for BEQ or (Ra!=Rb) for BNE. Taken: pc = pc + sext(R0) truncated to ADDR_W. Not taken: pc+1. All pc arithmetic wraps mod 2^ADDR_W.
- FSM states and transitions:
  - IDLE: on start, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On the cycle imem_req&&imem_ack, latch instr and go to DECODE; req=0 from the next cycle.
  - DECODE: read Ra, Rb. HALT goes to HALTED with pc=pc+1 and halted=1.
  - EXEC: compute ALU result or branch target. LW/SW go to MEM; all others go to WB.
  - MEM: dmem_req=1 with dmem_we/addr/wdata stable until dmem_ack. On ack, LW captures dmem_rdata and the state goes to WB.
  - WB: write Ra (except SW/BEQ/BNE/JR/NOP), update pc, go to FETCH.
  - HALTED: start clears halted and goes to FETCH at the current pc.
- Latency with zero-wait ack (ack high in the first req cycle):
  - ALU/branch instruction = 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW/SW = 5 cycles.
  - Each wait cycle adds 1.
- Requests never drop before ack. An ack without req is ignored. start is ignored while busy.
- Write-then-read of the same register in consecutive instructions sees the new value; no hazards exist, since the core is multicycle.

Optional Feature:
- Macro MC_CPU_TRACE_EN.
- Defined: adds outputs retire_valid (1), retire_pc (ADDR_W) and retire_instr (8).
  - retire_valid pulses for exactly one cycle in WB, or in DECODE for HALT.
  - retire_pc carries the instruction's fetch address; retire_instr carries its encoding.
  - All three reset to 0.
- Undefined: these ports do not exist; all other behaviour is identical.

Test Plan:
- Reset then start with zero-wait imem: program ADDI R1,3; ADDI R1,3; HALT -> R1=6, halted=1 and pc=3 after 4+4+2 cycles from start; busy low after HALT.
- DATA_W=8: R1=0x7F, R2=0x01, ADD R1,R2 -> R1=0x80, ovf=1. Then ADD R3,R3 with R3=0 -> ovf=0.
- Memory timing: SW R1,[R2] with R1=0xA5, R2=0x10, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with addr=0x10 and wdata=0xA5 stable. Then LW R3,[R2] returning 0xA5 -> R3=0xA5.
- Branches: R0=0xFE (-2) at pc=5, BEQ R1,R1 -> pc=3. BNE R1,R1 at pc=5 -> pc=6. JR R2 with R2=0x40 -> pc=0x40.
- Reset mid-operation: assert rst while imem_req is high and ack is withheld -> next cycle imem_req=0, pc=RESET_PC, state IDLE, registers 0, and no spurious write.
- ADDR_W=4 wrap: HALT at pc=15 -> pc=0. With MC_CPU_TRACE_EN, each retire gives one retire_valid pulse with matching retire_pc/retire_instr.
